product_accumulator: RTL and testbench

//  Downstream stage of the 4x4 array multiplier. Accepts one 8-bit product
//  per cycle over a valid/ready handshake and sums FRAME_LEN products into a

---
 rtl/product_accumulator_pkg.sv | 30 +++
 rtl/product_accumulator_adder.sv | 51 +++++
 rtl/product_accumulator.sv | 172 +++++++++++++++++
 tb/tb_product_accumulator.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/product_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// product_accumulator_pkg
//   Definitions shared by the 4x4 multiplier and its downstream accumulator:
//   the product width, the accumulator FSM state encoding, and a helper that
//   sizes the per-frame item counter.
// -----------------------------------------------------------------------------
package product_accumulator_pkg;

    // Width of the multiplier y output (4x4 unsigned -> 8 bits)
    localparam int PROD_W = 8;

    // Accumulator FSM states
    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Counter width for a frame of frame_len items (at least one bit)
    function automatic int cnt_width(input int frame_len);
        int w;
        w = $clog2(frame_len);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage : product_accumulator_pkg

// File: rtl/product_accumulator_adder.sv
// -----------------------------------------------------------------------------
// full_add / acc_adder
//   full_add : one-bit full adder cell.
//   acc_adder: W-bit ripple-carry adder chained from full_add cells. The
//              carry-out tells the accumulator that the true sum needs W+1
//              bits, i.e. the running total must saturate.
// Ports (acc_adder)
//   i_a   in  W   current accumulator value
//   i_b   in  W   zero-extended product
//   o_sum out W   low W bits of i_a + i_b
//   o_co  out 1   carry out of the MSB (saturation detect)
// -----------------------------------------------------------------------------
module full_add (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule : full_add

module acc_adder #(
    parameter int W = 10
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_co
);

    logic [W:0] w_c;

    assign w_c[0] = 1'b0;

    for (genvar g = 0; g < W; g++) begin : g_bit
        full_add u_fa (
            .i_a  (i_a[g]),
            .i_b  (i_b[g]),
            .i_ci (w_c[g]),
            .o_s  (o_sum[g]),
            .o_co (w_c[g+1])
        );
    end

    assign o_co = w_c[W];

endmodule : acc_adder

// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//   Sums FRAME_LEN unsigned products into a saturating frame total and
//   presents it, with a per-frame sticky saturation flag, on a valid/ready
//   output. While a finished frame waits in the output register the input
//   side stalls, which costs one bubble per frame at full rate.
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   clr        in   1       synchronous clear (drops partial and pending data)
//   in_valid   in   1       in_prod valid
//   in_ready   out  1       accumulator can take in_prod this cycle
//   in_prod    in   PROD_W  unsigned product
//   out_valid  out  1       out_sum/out_ovf hold a completed frame
//   out_ready  in   1       consumer takes the result
//   out_sum    out  ACC_W   saturated frame total
//   out_ovf    out  1       frame saturated at least once
// -----------------------------------------------------------------------------
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W    = product_accumulator_pkg::PROD_W,
    parameter int ACC_W     = 10,
    parameter int FRAME_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int CNT_W = cnt_width(FRAME_LEN);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_sum;
    logic               r_out_ovf;

    logic               w_in_ready;
    logic               w_xfer_in;
    logic               w_xfer_out;
    logic               w_last;
    logic [ACC_W-1:0]   w_prod_ext;
    logic [ACC_W-1:0]   w_sum;
    logic               w_sat;
    logic [ACC_W-1:0]   w_acc_nxt;

    assign w_in_ready = (r_state == ST_ACCUM) && !clr;
    assign w_xfer_in  = in_valid && w_in_ready;
    assign w_xfer_out = r_out_valid && out_ready;
    assign w_last     = (r_cnt == CNT_W'(FRAME_LEN - 1));
    assign w_prod_ext = ACC_W'(in_prod);

    // Carry-out of the adder means acc + prod does not fit in ACC_W bits
    acc_adder #(
        .W (ACC_W)
    ) u_acc_adder (
        .i_a   (r_acc),
        .i_b   (w_prod_ext),
        .o_sum (w_sum),
        .o_co  (w_sat)
    );

    assign w_acc_nxt = w_sat ? {ACC_W{1'b1}} : w_sum;

    // Next-state logic: clr forces ACCUM, otherwise frame end / output take
    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = ST_ACCUM;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_xfer_in && w_last) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_state_nxt = ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    if (w_xfer_out) begin
                        w_state_nxt = ST_ACCUM;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
                default: begin
                    w_state_nxt = ST_ACCUM;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accumulator, item counter and sticky saturation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= {ACC_W{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_acc <= {ACC_W{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
            r_ovf <= 1'b0;
        end else if (w_xfer_in) begin
            if (w_last) begin
                // Frame handed to the output register; start the next one clean
                r_acc <= {ACC_W{1'b0}};
                r_cnt <= {CNT_W{1'b0}};
                r_ovf <= 1'b0;
            end else begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
                r_ovf <= r_ovf | w_sat;
            end
        end else begin
            r_acc <= r_acc;
            r_cnt <= r_cnt;
            r_ovf <= r_ovf;
        end
    end

    // Output register: loaded on the last item, released on output transfer.
    // clr only drops out_valid; the sum/flag registers keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= {ACC_W{1'b0}};
            r_out_ovf   <= 1'b0;
        end else if (clr) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= r_out_sum;
            r_out_ovf   <= r_out_ovf;
        end else if (w_xfer_in && w_last) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_acc_nxt;
            r_out_ovf   <= r_ovf | w_sat;
        end else if (w_xfer_out) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= r_out_sum;
            r_out_ovf   <= r_out_ovf;
        end else begin
            r_out_valid <= r_out_valid;
            r_out_sum   <= r_out_sum;
            r_out_ovf   <= r_out_ovf;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_ovf   = r_out_ovf;

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_product_accumulator
//   Two instances: index 0 uses the default FRAME_LEN=4, index 1 uses
//   FRAME_LEN=8 so a full frame of 225s saturates the 10-bit total.
//   The reference model keeps a plain integer running sum per frame; the
//   saturated total is min(sum, 1023) and the flag is sum > 1023.
// -----------------------------------------------------------------------------
module tb_product_accumulator;

    localparam int ACC_MAX = 1023;

    logic       clk;
    logic       rst_n;
    logic [1:0] clr;
    logic [1:0] in_valid;
    logic [1:0] in_ready;
    logic [7:0] in_prod [2];
    logic [1:0] out_valid;
    logic [1:0] out_ready;
    logic [9:0] out_sum [2];
    logic [1:0] out_ovf;

    int flen [2] = '{4, 8};

    // Reference model state
    bit m_hold [2];
    int m_sum  [2];
    int m_cnt  [2];
    int m_osum [2];
    bit m_oovf [2];

    int n_vec = 0;
    int n_err = 0;

    product_accumulator #(.PROD_W(8), .ACC_W(10), .FRAME_LEN(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr[0]),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_prod   (in_prod[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_sum   (out_sum[0]),
        .out_ovf   (out_ovf[0])
    );

    product_accumulator #(.PROD_W(8), .ACC_W(10), .FRAME_LEN(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr[1]),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_prod   (in_prod[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_sum   (out_sum[1]),
        .out_ovf   (out_ovf[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s[dut%0d]: observed %0d, expected %0d (t=%0t)", tag, idx, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_hold[i] = 1'b0;
            m_sum[i]  = 0;
            m_cnt[i]  = 0;
            m_osum[i] = 0;
            m_oovf[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input int i);
        if (clr[i]) begin
            m_sum[i]  = 0;
            m_cnt[i]  = 0;
            m_hold[i] = 1'b0;
        end else if (!m_hold[i]) begin
            if (in_valid[i]) begin
                m_sum[i] = m_sum[i] + int'(in_prod[i]);
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == flen[i]) begin
                    m_osum[i] = (m_sum[i] > ACC_MAX) ? ACC_MAX : m_sum[i];
                    m_oovf[i] = (m_sum[i] > ACC_MAX);
                    m_hold[i] = 1'b1;
                    m_sum[i]  = 0;
                    m_cnt[i]  = 0;
                end
            end
        end else if (out_ready[i]) begin
            m_hold[i] = 1'b0;
        end
    endtask

    // One clock cycle: entered and left at posedge+1
    task automatic tick();
        #3;
        for (int i = 0; i < 2; i++) begin
            check("in_ready", i, 32'(in_ready[i]), 32'(!m_hold[i] && !clr[i]));
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            model_edge(i);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check("out_valid", i, 32'(out_valid[i]), 32'(m_hold[i]));
            check("out_sum",   i, 32'(out_sum[i]),   32'(m_osum[i]));
            check("out_ovf",   i, 32'(out_ovf[i]),   32'(m_oovf[i]));
        end
    endtask

    // Offer one product and hold it until accepted (bounded)
    task automatic send(input int i, input int p);
        bit acc;
        in_valid[i] = 1'b1;
        in_prod[i]  = 8'(p);
        for (int k = 0; k < 40; k++) begin
            acc = !m_hold[i] && !clr[i];
            tick();
            if (acc) begin
                in_valid[i] = 1'b0;
                return;
            end
        end
        in_valid[i] = 1'b0;
        n_vec++;
        n_err++;
        $display("FAIL send_timeout[dut%0d]: product %0d not accepted within 40 cycles", i, p);
    endtask

    task automatic send_frame(input int i, input int v0, input int v1, input int v2, input int v3);
        send(i, v0);
        send(i, v1);
        send(i, v2);
        send(i, v3);
    endtask

    task automatic random_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 2; i++) begin
                in_valid[i]  = 1'($urandom_range(0, 1));
                in_prod[i]   = 8'($urandom_range(0, 255));
                out_ready[i] = 1'($urandom_range(0, 3) != 0);
                clr[i]       = 1'($urandom_range(0, 15) == 0);
            end
            tick();
        end
        in_valid  = 2'b00;
        clr       = 2'b00;
        out_ready = 2'b11;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_valid"}, i, 32'(out_valid[i]), 32'd0);
            check({tag, "_sum"},   i, 32'(out_sum[i]),   32'd0);
            check({tag, "_ovf"},   i, 32'(out_ovf[i]),   32'd0);
            check({tag, "_ready"}, i, 32'(in_ready[i]),  32'd1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 2'b00;
        in_valid  = 2'b00;
        out_ready = 2'b11;
        in_prod[0] = 8'd0;
        in_prod[1] = 8'd0;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // 1: 3+5+7+9, result visible the cycle after the 4th transfer
        send_frame(0, 3, 5, 7, 9);
        check("t1_valid", 0, 32'(out_valid[0]), 32'd1);
        check("t1_sum",   0, 32'(out_sum[0]),   32'd24);
        check("t1_ovf",   0, 32'(out_ovf[0]),   32'd0);
        tick();

        // 2: four 15*15 products
        send_frame(0, 225, 225, 225, 225);
        check("t2_sum", 0, 32'(out_sum[0]), 32'd900);
        check("t2_ovf", 0, 32'(out_ovf[0]), 32'd0);
        tick();

        // 3: FRAME_LEN=8 saturates, next frame's flag is clean
        for (int k = 0; k < 8; k++) send(1, 225);
        check("t3_sum", 1, 32'(out_sum[1]), 32'd1023);
        check("t3_ovf", 1, 32'(out_ovf[1]), 32'd1);
        tick();
        for (int k = 0; k < 8; k++) send(1, 1);
        check("t3b_sum", 1, 32'(out_sum[1]), 32'd8);
        check("t3b_ovf", 1, 32'(out_ovf[1]), 32'd0);
        tick();

        // 4: backpressure holds the result and stalls the input
        out_ready[0] = 1'b0;
        send_frame(0, 50, 60, 70, 80);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_hold_sum",   0, 32'(out_sum[0]),   32'd260);
            check("t4_hold_ready", 0, 32'(in_ready[0]),  32'd0);
        end
        out_ready[0] = 1'b1;
        tick();
        check("t4_release_valid", 0, 32'(out_valid[0]), 32'd0);
        check("t4_release_ready", 0, 32'(in_ready[0]),  32'd1);

        // 5: partial frame abandoned by clr
        send(0, 10);
        send(0, 20);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        check("t5_no_out", 0, 32'(out_valid[0]), 32'd0);
        send_frame(0, 1, 2, 3, 4);
        check("t5_sum", 0, 32'(out_sum[0]), 32'd10);
        tick();

        // 6: random traffic, async reset mid-frame, then a clean frame
        random_cycles(150);
        send(0, 7);
        send(0, 8);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("async_rst");
        #1;
        rst_n = 1'b1;
        tick();
        check("t6_no_spurious", 0, 32'(out_valid[0]), 32'd0);
        send_frame(0, 100, 49, 36, 81);
        check("t6_sum", 0, 32'(out_sum[0]), 32'd266);
        tick();
        random_cycles(300);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_product_accumulator
